// File: rtl/qam_p2s.sv
// qam_p2s: 4-QAM symbol-to-serial converter.
// Decided 2-bit symbols enter a 2-entry FIFO. A three-state serializer sends
// each symbol as two bits, bit0 first, with one bit per data_change strobe.
//
// Handshake: symbol_valid is a one-cycle strobe. symbol_in is captured on
// the edge that closes a cycle where symbol_valid is high and either the FIFO
// has room or a pop happens in that same cycle. symbol_ready shows the room
// condition (count != 2) but does not include the pop case. If a symbol
// arrives when the FIFO is full and nothing pops, the symbol is dropped and
// overflow latches high. bit_valid pulses for one cycle each time adat_ki_S
// takes a new bit.
module qam_p2s (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] symbol_in,
   input  logic       symbol_valid,
   input  logic       data_change,
   output logic       adat_ki_S,
   output logic       bit_valid,
   output logic       bit_phase,
   output logic       symbol_ready,
   output logic       busy,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_t;

   state_t     r_state;
   logic [1:0] r_mem [0:1];
   logic [1:0] r_count;
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_shreg;
   logic       r_adat;
   logic       r_bit_valid;
   logic       r_bit_phase;
   logic       r_overflow;

   logic       w_nonempty;
   logic       w_pop;
   logic       w_push;
   logic       w_drop;
   logic [1:0] w_head;

   // The serializer pops from IDLE right away. From SEND1 it pops when the
   // last bit of the current symbol goes out, so the next symbol follows
   // with no gap.
   assign w_nonempty = (r_count != 2'd0);
   assign w_pop      = w_nonempty &
                       ((r_state == IDLE) | ((r_state == SEND1) & data_change));
   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // still accepted.
   assign w_push     = symbol_valid & ((r_count != 2'd2) | w_pop);
   assign w_drop     = symbol_valid & ~w_push;
   assign w_head     = r_mem[r_rptr];

   assign symbol_ready = (r_count != 2'd2);
   assign busy         = (r_state != IDLE);
   assign adat_ki_S    = r_adat;
   assign bit_valid    = r_bit_valid;
   assign bit_phase    = r_bit_phase;
   assign overflow     = r_overflow;

   // FIFO storage, pointers and occupancy count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mem[0] <= 2'b00;
         r_mem[1] <= 2'b00;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= symbol_in;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky drop flag. Only reset clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // Serializer FSM with registered serial outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_shreg     <= 2'b00;
         r_adat      <= 1'b0;
         r_bit_valid <= 1'b0;
         r_bit_phase <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shreg <= w_head;
                  r_state <= SEND0;
               end
            end
            SEND0: begin
               if (data_change) begin
                  r_adat      <= r_shreg[0];
                  r_bit_phase <= 1'b0;
                  r_bit_valid <= 1'b1;
                  r_state     <= SEND1;
               end
            end
            SEND1: begin
               if (data_change) begin
                  r_adat      <= r_shreg[1];
                  r_bit_phase <= 1'b1;
                  r_bit_valid <= 1'b1;
                  if (w_pop) begin
                     r_shreg <= w_head;
                     r_state <= SEND0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
